// File: rtl/spi_agc_pkg.sv
// spi_agc_pkg: frame geometry, opcodes and FSM state type shared by the AGC SPI master and responder.
package spi_agc_pkg;
    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS = 8;
    localparam int ADDR_W = 7;
    localparam int R1W0_BIT = FRAME_BITS - 1;
    localparam int CMD_RW_BIT = R1W0_BIT - (FRAME_BITS - CMD_BITS);
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ = 1'b1;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_DONE} state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizer plus one delay flop so the parent can form edge pulses.
module spi_pin_sync #(
    parameter logic INIT = 1'b0
) (
    input  logic main_clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic q_dly
);
    logic [2:0] s_q, s_d;
    always_comb s_d = {s_q[1:0], d};
    always_ff @(posedge main_clk or posedge reset)
        if (reset) s_q <= {3{INIT}};
        else s_q <= s_d;
    assign q = s_q[1];
    assign q_dly = s_q[2];
endmodule

// File: rtl/spi3w_agc_responder.sv
// spi3w_agc_responder: oversampled 3-wire SPI slave modelling the AGC register file.
// Read turnaround on SDIO exists only when SPI3W_RESP_READ_EN is defined.
module spi3w_agc_responder
    import spi_agc_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  spi_csb,
    input  logic                  spi_sclk,
    input  logic                  sdio_i,
    output logic                  sdio_o,
    output logic                  sdio_oe,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic                  wr_stb,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  frame_err
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    logic csb_s, csb_p, sclk_s, sclk_p, csb_rise, csb_fall, sclk_rise;
    logic [1:0] sdio_q, sdio_d;
    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [CMD_BITS-1:0] sh_q, sh_d, cmd_n;
    logic rw_q, rw_d, wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];
    spi_pin_sync #(.INIT(1'b1)) u_csb (.main_clk(main_clk), .reset(reset), .d(spi_csb), .q(csb_s), .q_dly(csb_p));
    spi_pin_sync #(.INIT(1'b0)) u_sclk (.main_clk(main_clk), .reset(reset), .d(spi_sclk), .q(sclk_s), .q_dly(sclk_p));
    assign sdio_d = {sdio_q[0], sdio_i};
    assign csb_rise = csb_s & ~csb_p;
    assign csb_fall = ~csb_s & csb_p;
    assign sclk_rise = sclk_s & ~sclk_p;
    assign cmd_n = {sh_q[CMD_BITS-2:0], sdio_q[1]};
    // csb is tested first so a coincident sclk edge is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sh_d = sh_q;
        rw_d = rw_q;
        addr_d = addr_q;
        wr_addr_d = wr_addr_q;
        regs_d = regs_q;
        wr_stb_d = 1'b0;
        frame_err_d = 1'b0;
        if (csb_rise) begin
            state_d = ST_IDLE;
            frame_err_d = state_q inside {ST_CMD, ST_WDATA, ST_RDATA};
            if (state_q == ST_DONE && rw_q == OP_WRITE) begin
                wr_stb_d = 1'b1;
                wr_addr_d = addr_q;
                if (32'(addr_q) < NUM_REGS) regs_d[addr_q[IDX_W-1:0]] = sh_q;
            end
        end else if (state_q == ST_IDLE) begin
            if (csb_fall) begin
                state_d = ST_CMD;
                cnt_d = '0;
                sh_d = '0;
            end
        end else if (sclk_rise && state_q != ST_DONE) begin
            sh_d = cmd_n;
            cnt_d = cnt_q + 5'd1;
            if (state_q == ST_CMD && cnt_q == 5'(CMD_BITS - 1)) begin
                rw_d = cmd_n[CMD_RW_BIT];
                addr_d = cmd_n[ADDR_W-1:0];
                state_d = (cmd_n[CMD_RW_BIT] == OP_READ) ? ST_RDATA : ST_WDATA;
            end
            if (cnt_q == 5'(FRAME_BITS - 1)) state_d = ST_DONE;
        end
    end
    always_ff @(posedge main_clk or posedge reset)
        if (reset) begin
            sdio_q <= '0;
            state_q <= ST_IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            rw_q <= 1'b0;
            addr_q <= '0;
            wr_addr_q <= '0;
            wr_stb_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
        end else begin
            sdio_q <= sdio_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            rw_q <= rw_d;
            addr_q <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_stb_q <= wr_stb_d;
            frame_err_q <= frame_err_d;
            regs_q <= regs_d;
        end
    for (genvar g = 0; g < NUM_REGS; g++) assign reg_q[8*g +: 8] = regs_q[g];
    assign wr_stb = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign frame_err = frame_err_q;
`ifdef SPI3W_RESP_READ_EN
    logic sclk_fall, so_q, so_d, oe_q, oe_d;
    logic [7:0] rd_q, rd_d;
    assign sclk_fall = ~sclk_s & sclk_p;
    // Snapshot the addressed register on the 8th rise, then shift it out MSB first on falls.
    always_comb begin
        rd_d = rd_q;
        so_d = so_q;
        oe_d = oe_q;
        if (csb_rise) oe_d = 1'b0;
        else if (state_q == ST_CMD && sclk_rise && cnt_q == 5'(CMD_BITS - 1))
            rd_d = (32'(cmd_n[ADDR_W-1:0]) < NUM_REGS) ? regs_q[cmd_n[IDX_W-1:0]] : 8'h00;
        else if (state_q == ST_RDATA && sclk_fall) begin
            oe_d = 1'b1;
            so_d = rd_q[7];
            rd_d = {rd_q[6:0], 1'b0};
        end
    end
    always_ff @(posedge main_clk or posedge reset)
        if (reset) begin
            rd_q <= '0;
            so_q <= 1'b0;
            oe_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
            so_q <= so_d;
            oe_q <= oe_d;
        end
    assign sdio_o = so_q;
    assign sdio_oe = oe_q;
`else
    assign sdio_o = 1'b0;
    assign sdio_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi3w_agc_responder.sv
// tb_spi3w_agc_responder: table-driven frame vectors plus reset-mid-read and coincident-edge sequences.
module tb_spi3w_agc_responder;
`ifdef SPI3W_RESP_READ_EN
    localparam bit RD = 1'b1;
`else
    localparam bit RD = 1'b0;
`endif
    typedef struct {
        logic [15:0] f;
        int          nr;
        bit          co;
        bit          stb;
        bit          err;
        logic [7:0]  rd;
        logic [15:0] oe;
    } vec_t;
    logic clk = 0, rst = 1, csb = 1, sclk = 0, sdi = 0;
    logic sdo, oe, stb, ferr;
    logic [63:0] regs;
    logic [6:0] waddr;
    int checks = 0, failures = 0, stb_cnt = 0, err_cnt = 0;
    logic [7:0] m [8];
    logic [6:0] m_waddr = '0;
    vec_t tv [12];
    spi3w_agc_responder dut (
        .main_clk(clk), .reset(rst), .spi_csb(csb), .spi_sclk(sclk), .sdio_i(sdi),
        .sdio_o(sdo), .sdio_oe(oe), .reg_q(regs), .wr_stb(stb), .wr_addr(waddr), .frame_err(ferr)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (stb) stb_cnt <= stb_cnt + 1;
        if (ferr) err_cnt <= err_cnt + 1;
    end
    function automatic logic [63:0] model_flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i];
        return r;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    task automatic run_vec(input int idx, input vec_t v);
        int s0, e0;
        logic [7:0] rd = '0;
        logic [15:0] oev = '0;
        logic oe_after;
        s0 = stb_cnt;
        e0 = err_cnt;
        csb = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < v.nr; i++) begin
            sdi = v.f[15-i];
            repeat (8) @(negedge clk);
            oev[i] = oe;
            if (i >= 8) rd[15-i] = sdo;
            sclk = 1;
            if (v.co && i == v.nr - 1) csb = 1;
            repeat (8) @(negedge clk);
            sclk = 0;
        end
        if (!v.co) begin
            repeat (8) @(negedge clk);
            csb = 1;
        end
        repeat (4) @(negedge clk);
        oe_after = oe;
        repeat (8) @(negedge clk);
        if (v.stb) begin
            m_waddr = v.f[14:8];
            if (v.f[14:8] < 7'd8) m[v.f[10:8]] = v.f[7:0];
        end
        chk($sformatf("v%0d wr_stb_count", idx), 64'(stb_cnt - s0), 64'(v.stb));
        chk($sformatf("v%0d frame_err_count", idx), 64'(err_cnt - e0), 64'(v.err));
        chk($sformatf("v%0d wr_addr", idx), 64'(waddr), 64'(m_waddr));
        chk($sformatf("v%0d reg_q", idx), regs, model_flat());
        chk($sformatf("v%0d read_bits", idx), 64'(rd), 64'(v.rd));
        chk($sformatf("v%0d oe_at_rises", idx), 64'(oev), 64'(v.oe));
        chk($sformatf("v%0d oe_after_csb", idx), 64'(oe_after), 64'd0);
    endtask
    initial begin
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        tv[0]  = '{16'h035A, 16, 0, 1, 0, 8'h00, 16'h0000};
        tv[1]  = '{16'h02C3, 16, 0, 1, 0, 8'h00, 16'h0000};
        tv[2]  = '{16'h8200, 16, 0, 0, 0, RD ? 8'hC3 : 8'h00, RD ? 16'hFF00 : 16'h0000};
        tv[3]  = '{16'h01FF, 11, 0, 0, 1, 8'h00, 16'h0000};
        tv[4]  = '{16'h0111, 16, 0, 1, 0, 8'h00, 16'h0000};
        tv[5]  = '{16'h0977, 16, 0, 1, 0, 8'h00, 16'h0000};
        tv[6]  = '{16'h8900, 16, 0, 0, 0, 8'h00, RD ? 16'hFF00 : 16'h0000};
        tv[7]  = '{16'h8300, 12, 0, 0, 1, RD ? 8'h50 : 8'h00, RD ? 16'h0F00 : 16'h0000};
        tv[8]  = '{16'h0542, 16, 1, 0, 1, 8'h00, 16'h0000};
        tv[9]  = '{16'h00A5, 16, 0, 1, 0, 8'h00, 16'h0000};
        tv[10] = '{16'h073C, 16, 0, 1, 0, 8'h00, 16'h0000};
        tv[11] = '{16'h8700, 16, 0, 0, 0, RD ? 8'h3C : 8'h00, RD ? 16'hFF00 : 16'h0000};
        repeat (3) @(negedge clk);
        chk("reset reg_q", regs, 64'd0);
        chk("reset outputs", {60'd0, sdo, oe, stb, ferr}, 64'd0);
        chk("reset wr_addr", 64'(waddr), 64'd0);
        rst = 0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 12; k++) run_vec(k, tv[k]);
        csb = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            sdi = i < 8 ? 1'(16'h8200 >> (15 - i)) : 1'b0;
            repeat (8) @(negedge clk);
            sclk = 1;
            if (i < 11) begin
                repeat (8) @(negedge clk);
                sclk = 0;
            end
        end
        repeat (4) @(negedge clk);
        chk("pre-reset oe", 64'(oe), 64'(RD));
        rst = 1;
        #1;
        chk("mid-read reset oe", 64'(oe), 64'd0);
        chk("mid-read reset reg_q", regs, 64'd0);
        sclk = 0;
        csb = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        m_waddr = '0;
        repeat (6) @(negedge clk);
        chk("post-reset wr_addr", 64'(waddr), 64'd0);
        run_vec(12, '{16'h0466, 16, 0, 1, 0, 8'h00, 16'h0000});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #3000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/spi3w_agc_responder.md
Name: spi3w_agc_responder

Overview:
- Synthesizable 3-wire SPI responder (slave) that models the AGC device register file.
- Target for the SPI AGC master: decodes CSB/SCLK/SDIO frames, commits writes to a small register file, and turns SDIO around to return read data.
- Exposes the register contents and write strobes so loopback benches and on-board self-test can check master traffic without the physical chip.
- Oversamples all SPI pins with main_clk; no SCLK-domain logic.

Parameters:
- NUM_REGS, 8, register count; address decode uses the low log2(NUM_REGS) bits of the 7-bit address field.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- main_clk  in  1  system clock; must be at least 8x SCLK frequency.
- reset  in  1  asynchronous, active-high.
- spi_csb  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock, idle low.
- sdio_i  in  1  SDIO input from the pad buffer.
- sdio_o  out  1  SDIO output to the pad buffer.
- sdio_oe  out  1  1 = responder drives SDIO.
- reg_q  out  NUM_REGS*8  register file, flat; reg n sits at bits [8n+7:8n].
- wr_stb  out  1  one-cycle pulse when a write commits.
- wr_addr  out  7  address of the last committed write.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: all registers = RST_VAL; sdio_o=0; sdio_oe=0; wr_stb=0; wr_addr=0; frame_err=0; FSM=IDLE; bit counter=0.
- Input sync: csb, sclk and sdio each pass through 2-flop synchronizers.
- Edge detect: a third flop on sclk and csb gives one-cycle rise/fall pulses.
- Pin-to-action latency is 3 main_clk cycles.
- Frame format: 16 bits, MSB first, sampled on SCLK rising edge.
  - bit15 = R1W0.
  - bits14:8 = address.
  - bits7:0 = data.
- FSM states: IDLE, CMD, WDATA, RDATA, DONE.
- IDLE -> CMD on csb falling edge; clear shift register and bit counter.
- CMD: shift in on each sclk rise.
  - After the 8th rise, latch R1W0 and address.
  - Go to WDATA if R1W0=0, else RDATA.
- WDATA: shift in 8 data bits on sclk rises; after the 16th rise go to DONE.
- RDATA:
  - On the first sclk fall after the 8th rise: sdio_oe=1 and sdio_o = bit7 of the addressed register.
  - Each later sclk fall: shift out the next bit.
  - The register value is snapshotted when RDATA is entered.
  - After the 16th rise go to DONE.
  - sdio_oe stays 1 until csb rises.
- DONE: further sclk edges are ignored; sdio_o holds its value.
- csb rising edge:
  - From DONE: if the frame was a write, update the register and drive wr_addr with wr_stb=1 in the same cycle. Then sdio_oe=0 and go to IDLE.
  - From CMD, WDATA or RDATA (short frame): no write, frame_err=1 for one cycle, sdio_oe=0, go to IDLE.
- Out-of-range address (index >= NUM_REGS):
  - Write: wr_stb still pulses; no register changes.
  - Read: returns 8'h00.
- Simultaneous csb rise and sclk rise in the same cycle: csb wins; the sclk edge is discarded.
- Reset asserted mid-frame: immediate return to reset state, including sdio_oe=0.

Optional Feature:
- Macro SPI3W_RESP_READ_EN.
- Defined: read frames behave as described above.
- Undefined:
  - sdio_oe is tied to 0 and sdio_o to 0.
  - Read frames are decoded, counted to 16 bits and completed silently.
  - No register change and no wr_stb on read frames.

Decomposition:
- Shared package spi_agc_pkg holds:
  - FRAME_BITS=16, CMD_BITS=8, ADDR_W=7.
  - The R1W0 bit position.
  - The state enum type.
  - The read/write opcode constants, shared with the master.
- One sub-module, spi_pin_sync: 2-flop synchronizer plus edge-detect flop.
  - Instantiated once each for csb and sclk.
  - sdio uses only the synchronizer part.

Test Plan:
- Write: frame 0x0_03_5A (W, addr 3, data 5A), SCLK = main_clk/16.
  - reg_q[31:24]=8'h5A one cycle after csb rise.
  - wr_stb pulses once; wr_addr=3.
  - All other registers unchanged.
- Read: preload reg 2 = 8'hC3, then send R frame addr 2.
  - sdio_oe rises after the 8th SCLK fall.
  - Master samples 1,1,0,0,0,0,1,1 on rises 9-16.
  - sdio_oe=0 within 4 cycles of csb high.
- Abort: csb rises after 11 SCLK rises of a write to addr 1 with data 0xFF.
  - frame_err pulses; no wr_stb; reg 1 unchanged.
  - The next full write of 0x11 to reg 1 succeeds.
- Out of range: write 0x77 to addr 9 with NUM_REGS=8.
  - wr_stb pulses with wr_addr=9; no reg_q bit changes.
  - Read of addr 9 returns 0x00.
- Reset mid-read: assert reset during bit 12 of a read.
  - sdio_oe=0 and all regs=RST_VAL immediately.
  - FSM in IDLE; the next write frame works.
- Macro off: repeat the read scenario.
  - sdio_oe never asserts; no frame_err; registers unchanged.
